lab5_ram_loader: RTL and testbench
==================================

// Module: lab5_ram_loader
// PURPOSE
//   Upstream feeder for the Lab 5 control/datapath. Takes a valid/ready word
//   stream from the host, writes it into the shared RAM from address 0, and
//   stops at a zero word (the same terminator the control FSM detects via
//   ram_zero). It then pulses start and owns no RAM port until the control
//   block reports done. After done it returns to loading for the next program.
// PARAMETERS
//   ADDR_WIDTH  8   RAM address width; DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  32  RAM word / stream width
// PORTS
//   clk         in   1           system clock, all state on posedge
//   rst         in   1           synchronous, active-high reset
//   in_valid    in   1           host word valid
//   in_data     in   DATA_WIDTH  host word
//   in_ready    out  1           loader can accept a word this cycle
//   ctrl_done   in   1           control block finished (level or pulse)
//   ram_we      out  1           RAM write enable (registered)
//   ram_addr    out  ADDR_WIDTH  RAM write address (registered)
//   ram_wdata   out  DATA_WIDTH  RAM write data (registered)
//   start       out  1           one-cycle pulse: program loaded, run
//   busy        out  1           high from start pulse until ctrl_done seen
//   word_count  out  ADDR_WIDTH+1  words written in current load, incl. terminator
//   overflow    out  1           sticky: program truncated at RAM end
// BEHAVIOUR
//   Reset: state=LOAD, wr_ptr=0, in_ready=1, ram_we=0, ram_addr=0,
//     ram_wdata=0, start=0, busy=0, word_count=0, overflow=0.
//   Handshake: accept = in_valid & in_ready; in_ready is a pure function of
//     state (1 only in LOAD); no combinational path from in_valid.
//   LOAD: on accept, next cycle ram_we=1, ram_addr=wr_ptr, ram_wdata=word;
//     wr_ptr++ and word_count++. Back-to-back accepts sustain 1 word/cycle.
//     ram_we=0 on any cycle without an accept in the prior cycle.
//     First accept of a load clears overflow and word_count (count becomes 1).
//     If word==0: write it, go to TERM.
//     If wr_ptr==DEPTH-1 and word!=0: write 0 instead (forced terminator),
//       set overflow=1, go to TERM. The RAM never holds an unterminated program.
//   TERM: in_ready=0; one cycle later, allowing the terminator write to land,
//     go to RUN. start=1 for exactly the first cycle of RUN; busy=1 same edge.
//   RUN: in_ready=0, ram_we=0; wait for ctrl_done. ctrl_done in the start
//     cycle counts. On ctrl_done: busy=0, wr_ptr=0, go to LOAD. word_count
//     and overflow hold until the next load's first accept.
//   ctrl_done outside RUN: ignored. in_valid outside LOAD: not accepted, the
//     host must hold.
//   Latency: terminator accept at cycle T -> write at T+1 -> start at T+2.
//   Reset mid-operation (any state): next edge gives full reset values; a
//     write scheduled for that edge is dropped and start is never emitted.
//   Widths: word_count is ADDR_WIDTH+1 bits so DEPTH (256) is representable.
// TESTING
//   1. Stream 5,7,0 back-to-back -> writes (0,5),(1,7),(2,0) on consecutive
//      cycles; start pulses 2 cycles after 0 accepted; word_count=3.
//   2. Stream 0 only -> single write (0,0); start; word_count=1; overflow=0.
//   3. Stream 256 nonzero words (0x1..0x100) -> addr 255 written with 0,
//      overflow=1, word_count=256, in_ready=0 after the 256th accept.
//   4. In RUN, drive in_valid=1 with 0xAA, then ctrl_done=1 for 1 cycle ->
//      0xAA is not accepted in RUN; busy falls; next write goes to addr 0.
//   5. Assert rst one cycle after terminator accept -> no ram_we next cycle,
//      no start, all outputs at reset values.
//   6. Gappy in_valid (1,0,0,1,0,1 with data 3,-,-,4,-,0) -> ram_we only
//      after each accept; addrs 0,1,2; ctrl_done before start ignored.

Source files
------------

// File: rtl/lab5_ram_loader.sv
// lab5_ram_loader: feeds a host valid/ready word stream into the shared Lab 5
// RAM starting at address 0, stops at a zero terminator (forcing one at the
// last address if the program is too long), then pulses start and stays off
// the RAM port until the control block reports done.
module lab5_ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  ctrl_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    TERM = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  first_pending;  // next accept is the first of a new load
  logic                  accept;

  // Ready depends on state only, so the host sees no path from in_valid.
  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;

  // Loader FSM with all outputs registered; ram_we and start default low so
  // each is a single-cycle pulse unless re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      wr_ptr        <= '0;
      first_pending <= 1'b1;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      word_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; the later assignment
      // in program order wins, which the overflow clear/set below relies on.
      ram_we <= 1'b0;
      start  <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            ram_we        <= 1'b1;
            ram_addr      <= wr_ptr;
            wr_ptr        <= wr_ptr + 1'b1;
            first_pending <= 1'b0;
            if (first_pending) begin
              word_count <= (ADDR_WIDTH + 1)'(1);
              overflow   <= 1'b0;
            end else begin
              word_count <= word_count + 1'b1;
            end
            if (in_data == '0) begin
              ram_wdata <= in_data;
              state     <= TERM;
            end else if (wr_ptr == LAST_ADDR) begin
              // Out of RAM: replace the word with a terminator so the
              // control block never runs off the end of memory.
              ram_wdata <= '0;
              overflow  <= 1'b1;
              state     <= TERM;
            end else begin
              ram_wdata <= in_data;
            end
          end
        end
        TERM: begin
          // Terminator write lands this cycle; hand over to control next.
          state <= RUN;
          start <= 1'b1;
          busy  <= 1'b1;
        end
        RUN: begin
          if (ctrl_done) begin
            busy          <= 1'b0;
            wr_ptr        <= '0;
            first_pending <= 1'b1;
            state         <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_ram_loader.sv
// Scoreboard bench for lab5_ram_loader: stimulus pushes expected RAM writes
// into a queue, an independent monitor pops and compares on every ram_we.
module tb_lab5_ram_loader;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ctrl_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          start;
  logic          busy;
  logic [AW:0]   word_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  wr_t exp_q[$];

  lab5_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ctrl_done (ctrl_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .start     (start),
    .busy      (busy),
    .word_count(word_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, ram_addr, ram_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_addr), 64'(e.addr));
        check("wr_data", 64'(ram_wdata), 64'(e.data));
      end
    end
  end

  // Present a word and hold it until accepted; records the expected write.
  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [DW-1:0] wexp);
    int n;
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("accept_timeout", 64'(n), 64'd0);
    e.addr = a;
    e.data = wexp;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // After a terminator accept: write cycle, then one-cycle start with busy.
  task automatic expect_start(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_start_early"}, 64'(start), 64'd0);
    check({tag, "_ready_term"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({tag, "_start"}, 64'(start), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_start_one"}, 64'(start), 64'd0);
    check({tag, "_busy_hold"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_run(input string tag);
    @(posedge clk); #1;
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    @(negedge clk);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int s0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    ctrl_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1;

    // 1: back-to-back 5,7,0
    push(32'd5, 8'd0, 32'd5);
    push(32'd7, 8'd1, 32'd7);
    push(32'd0, 8'd2, 32'd0);
    expect_start("t1");
    check("t1_count", 64'(word_count), 64'd3);
    check("t1_ovf", 64'(overflow), 64'd0);
    finish_run("t1");

    // 2: lone terminator; ctrl_done raised during the start cycle
    push(32'd0, 8'd0, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_start_early", 64'(start), 64'd0);
    @(posedge clk); #1;
    ctrl_done = 1'b1;
    @(negedge clk);
    check("t2_start", 64'(start), 64'd1);
    check("t2_count", 64'(word_count), 64'd1);
    check("t2_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    @(negedge clk);
    check("t2_busy_fall", 64'(busy), 64'd0);
    check("t2_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 3: 256 nonzero words -> forced terminator at address 255
    for (int i = 0; i < 256; i++) begin
      push(DW'(i + 1), AW'(i), (i == 255) ? 32'd0 : DW'(i + 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_ready_low", 64'(in_ready), 64'd0);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_count", 64'(word_count), 64'd256);
    @(negedge clk);
    check("t3_start", 64'(start), 64'd1);

    // 4: host word offered during RUN is held off; done returns to addr 0
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'hAA;
    repeat (3) begin
      @(negedge clk);
      check("t4_ready_run", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("t4_busy_fall", 64'(busy), 64'd0);
    check("t4_ovf_hold", 64'(overflow), 64'd1);
    check("t4_count_hold", 64'(word_count), 64'd256);
    @(posedge clk); #1;
    push(32'h11, 8'd0, 32'h11);
    @(negedge clk);
    check("t4_ovf_clr", 64'(overflow), 64'd0);
    check("t4_count_new", 64'(word_count), 64'd1);
    push(32'd0, 8'd1, 32'd0);
    expect_start("t4");
    finish_run("t4");

    // 6: gappy valid, stray ctrl_done during LOAD
    push(32'd3, 8'd0, 32'd3);
    idle(1);
    ctrl_done = 1'b1;
    idle(1);
    ctrl_done = 1'b0;
    @(negedge clk);
    check("t6_done_ignored_busy", 64'(busy), 64'd0);
    check("t6_done_ignored_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push(32'd4, 8'd1, 32'd4);
    idle(1);
    push(32'd0, 8'd2, 32'd0);
    expect_start("t6");
    check("t6_count", 64'(word_count), 64'd3);
    finish_run("t6");

    // 5: reset one cycle after terminator accept
    push(32'd9, 8'd0, 32'd9);
    push(32'd0, 8'd1, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    s0       = start_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_we", 64'(ram_we), 64'd0);
    check("t5_start", 64'(start), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_ready", 64'(in_ready), 64'd1);
    check("t5_addr", 64'(ram_addr), 64'd0);
    check("t5_wdata", 64'(ram_wdata), 64'd0);
    check("t5_count", 64'(word_count), 64'd0);
    check("t5_ovf", 64'(overflow), 64'd0);
    repeat (4) @(negedge clk);
    check("t5_no_start", 64'(start_cnt), 64'(s0));

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
